my_fifo: RTL and testbench

- Single-clock synchronous FIFO with registered read data and FULL/EMPTY status flags.
- Buffers W-bit words between a producer (wr_en/data_in) and a consumer (rd_en/data_out) in the same clock domain.
- Depth is 2**D entries: 16 with the defaults.
- Overflowing writes and underflowing reads are silently ignored.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_mem.sv | 22 ++
 rtl/my_fifo.sv | 45 ++++
 tb/tb_my_fifo.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared default sizes and pointer type for the my_fifo slice
package fifo_pkg;
  localparam int FIFO_W = 4;
  localparam int FIFO_D = 4;
  typedef logic [FIFO_D:0] ptr_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 2**D x W register array, sync write port, registered read port
// Ports: clk, rst (async, clears rdata only), we/waddr/wdata write, re/raddr/rdata read.
module fifo_mem #(
  parameter int W = 4,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [D-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [2**D];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/my_fifo.sv
// my_fifo: single-clock FIFO, depth 2**D, registered read data, FULL/EMPTY flags
// Ports: clk, rst (async active-high), wr_en/data_in push side,
// rd_en/data_out pop side, FULL/EMPTY status decoded from the pointers.
module my_fifo
  import fifo_pkg::*;
#(
  parameter int W = FIFO_W,
  parameter int D = FIFO_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_en,
  input  logic         wr_en,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         FULL,
  output logic         EMPTY
);
  // Extra MSB is a wrap bit: equal pointers mean empty, equal index with
  // differing wrap bits means full.
  logic [D:0] wptr, rptr;
  logic push, pop;
  assign EMPTY = wptr == rptr;
  assign FULL  = (wptr[D-1:0] == rptr[D-1:0]) && (wptr[D] != rptr[D]);
  assign push  = wr_en && !FULL;
  assign pop   = rd_en && !EMPTY;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= push ? wptr + 1'b1 : wptr;
      rptr <= pop ? rptr + 1'b1 : rptr;
    end
  fifo_mem #(.W(W), .D(D)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wptr[D-1:0]),
    .wdata (data_in),
    .re    (pop),
    .raddr (rptr[D-1:0]),
    .rdata (data_out)
  );
endmodule

// File: tb/tb_my_fifo.sv
// tb_my_fifo: directed-vector bench for my_fifo
module tb_my_fifo;
  logic clk = 0, rst = 1, rd_en = 0, wr_en = 0;
  logic [3:0] data_in = '0, data_out;
  logic full, empty;
  int n_vec = 0, n_bad = 0;
  my_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .data_out (data_out),
    .FULL     (full),
    .EMPTY    (empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic flags(input string tag, input logic e, input logic f);
    chk({tag, "_empty"}, 8'(empty), 8'(e));
    chk({tag, "_full"}, 8'(full), 8'(f));
  endtask
  initial begin
    logic [3:0] exp_q [$];
    tick;
    tick;
    flags("reset", 1, 0);
    chk("reset_dout", 8'(data_out), 8'h0);
    rst = 0;
    rd_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("empty_rd_dout", 8'(data_out), 8'h0);
      flags("empty_rd", 1, 0);
    end
    rd_en = 0;
    wr_en = 1;
    for (int i = 0; i < 16; i++) begin
      data_in = 4'(i);
      tick;
      flags("fill", 0, i == 15);
    end
    data_in = 4'hA;
    tick;
    flags("overflow", 0, 1);
    wr_en = 0;
    rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("drain_dout", 8'(data_out), 8'(i));
      flags("drain", i == 15, 0);
    end
    tick;
    chk("underflow_dout", 8'(data_out), 8'hF);
    flags("underflow", 1, 0);
    rd_en = 0;
    wr_en = 1;
    for (int i = 3; i <= 7; i++) begin
      data_in = 4'(i);
      tick;
    end
    rd_en = 1;
    data_in = 4'hC;
    for (int i = 3; i <= 6; i++) begin
      tick;
      chk("rw_dout", 8'(data_out), 8'(i));
      flags("rw", 0, 0);
    end
    rd_en = 0;
    for (int i = 0; i < 11; i++) begin
      data_in = 4'(i);
      tick;
      flags("wrap_fill", 0, i == 10);
    end
    rd_en = 1;
    data_in = 4'h9;
    tick;
    chk("full_rw_dout", 8'(data_out), 8'h7);
    flags("full_rw", 0, 0);
    wr_en = 0;
    exp_q = '{4'hC, 4'hC, 4'hC, 4'hC, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
              4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("wrap_drain_dout", 8'(data_out), 8'(exp_q[i]));
      flags("wrap_drain", i == 14, 0);
    end
    tick;
    chk("wrap_under_dout", 8'(data_out), 8'hA);
    rd_en = 0;
    wr_en = 1;
    for (int i = 1; i <= 3; i++) begin
      data_in = 4'(i);
      tick;
    end
    wr_en = 0;
    rd_en = 1;
    tick;
    chk("mid_dout", 8'(data_out), 8'h1);
    rd_en = 0;
    rst = 1;
    #1;
    chk("async_rst_dout", 8'(data_out), 8'h0);
    flags("async_rst", 1, 0);
    #1;
    rst = 0;
    rd_en = 1;
    tick;
    chk("post_rst_dout", 8'(data_out), 8'h0);
    flags("post_rst", 1, 0);
    rd_en = 0;
    wr_en = 1;
    data_in = 4'h5;
    tick;
    flags("post_rst_wr", 0, 0);
    wr_en = 0;
    rd_en = 1;
    tick;
    chk("post_rst_rd", 8'(data_out), 8'h5);
    flags("post_rst_rd", 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
